// File: rtl/myproject_div_pkg.sv
// ============================================================================
// myproject_div_pkg : shared types and helpers for the sequential dividers
// Revision 1.0
// ============================================================================
`default_nettype none

package myproject_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to hold a down-counter starting at width-1 (never fewer than one).
  function automatic int clog2cnt(input int width);
    int n;
    n = 1;
    while ((1 << n) < width) n++;
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/myproject_div_step.sv
// ============================================================================
// myproject_div_step : one combinational restoring-division step
// Revision 1.0
// ============================================================================
`default_nettype none

module myproject_div_step #(
  parameter int DIVISOR_WIDTH = 7
) (
  input  logic [DIVISOR_WIDTH:0]   prem,
  input  logic                     dvd_bit,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   prem_next,
  output logic                     q_bit
);

  logic [DIVISOR_WIDTH:0]   w_left;
  logic [DIVISOR_WIDTH+1:0] w_trial;
  logic                     w_unused_prem_msb;

  // The partial remainder stays below the divisor, so its top bit never
  // contributes to the shifted-in operand.
  assign w_unused_prem_msb = prem[DIVISOR_WIDTH];

  assign w_left    = {prem[DIVISOR_WIDTH-1:0], dvd_bit};
  assign w_trial   = {1'b0, w_left} - {2'b00, divisor};
  assign q_bit     = ~w_trial[DIVISOR_WIDTH+1];
  assign prem_next = q_bit ? w_trial[DIVISOR_WIDTH:0] : w_left;

endmodule

`default_nettype wire

// File: rtl/myproject_udiv_13ns_7ns_13_seq.sv
// ============================================================================
// myproject_udiv_13ns_7ns_13_seq : radix-2 restoring unsigned divider,
// one quotient bit per clock, valid/ready on both sides.
// Revision 1.0
// ============================================================================
`default_nettype none

module myproject_udiv_13ns_7ns_13_seq
  import myproject_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 13
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int                 c_cnt_w      = clog2cnt(din0_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(din0_WIDTH - 1);
  localparam int                 c_unused_id  = ID;

  if (dout_WIDTH != din0_WIDTH) begin : g_width_check
    $error("myproject_udiv instance %0d: dout_WIDTH must equal din0_WIDTH", ID);
  end

  div_state_t              r_state;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [din0_WIDTH-1:0]   r_shift;
  logic [din1_WIDTH-1:0]   r_divisor;
  logic [din1_WIDTH:0]     r_prem;
  logic [din1_WIDTH:0]     w_prem_next;
  logic                    w_q_bit;

  myproject_div_step #(
    .DIVISOR_WIDTH (din1_WIDTH)
  ) u_step (
    .prem      (r_prem),
    .dvd_bit   (r_shift[din0_WIDTH-1]),
    .divisor   (r_divisor),
    .prem_next (w_prem_next),
    .q_bit     (w_q_bit)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // r_shift holds the dividend on entry; quotient bits fill in from the LSB
  // as dividend bits leave at the MSB, so after the last step it is the quotient.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_divisor   <= '0;
      r_prem      <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift     <= din0;
            r_divisor   <= din1;
            r_prem      <= '0;
            r_cnt       <= c_cnt_last;
            div_by_zero <= (din1 == '0);
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          r_prem  <= w_prem_next;
          r_shift <= {r_shift[din0_WIDTH-2:0], w_q_bit};
          if (r_cnt == '0) begin
            quot    <= {r_shift[din0_WIDTH-2:0], w_q_bit};
            rem     <= w_prem_next[din1_WIDTH-1:0];
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_myproject_udiv_13ns_7ns_13_seq.sv
// ============================================================================
// tb_myproject_udiv_13ns_7ns_13_seq : self-checking bench with a transaction
// level model of the divider's handshake and arithmetic.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_myproject_udiv_13ns_7ns_13_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] din0;
  logic [6:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] quot;
  logic [6:0]  rem;
  logic        div_by_zero;

  myproject_udiv_13ns_7ns_13_seq #(
    .ID         (1),
    .din0_WIDTH (13),
    .din1_WIDTH (7),
    .dout_WIDTH (13)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: one outstanding operation, its age in edges, and its expected result.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  logic [12:0] m_q;
  logic [6:0]  m_r;
  logic        m_z;
  int          n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the pre-edge handshake, then
  // compare every observable output at the following falling edge.
  task automatic step();
    if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_z    = (din1 == 7'd0);
        if (din1 == 7'd0) begin
          m_q = 13'h1FFF;
          m_r = din0[6:0];
        end else begin
          m_q = din0 / 13'(din1);
          m_r = 7'(din0 % 13'(din1));
        end
      end
    end else if (m_age >= 13 && out_ready) begin
      m_busy = 1'b0;
      n_done++;
    end else if (m_age < 13) begin
      m_age++;
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_busy && m_age >= 13);
    if (m_busy && m_age >= 13) begin
      chk("quot", quot, m_q);
      chk("rem", rem, m_r);
      chk("div_by_zero", div_by_zero, m_z);
    end
  endtask

  task automatic rand_operands();
    case ($urandom_range(0, 7))
      0:       din1 = 7'd0;
      1:       din1 = 7'd1;
      2:       din1 = 7'd127;
      default: din1 = 7'($urandom_range(0, 127));
    endcase
    case ($urandom_range(0, 7))
      0:       din0 = 13'h1FFF;
      1:       din0 = 13'd0;
      default: din0 = 13'($urandom_range(0, 8191));
    endcase
  endtask

  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int ez, input int hold, input bit noisy);
    int lat;
    chk("idle_before_op", in_ready, 1);
    din0      = 13'(a);
    din1      = 7'(b);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = noisy;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noisy) rand_operands();
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 13);
    chk("lit_quot", quot, eq);
    chk("lit_rem", rem, er);
    chk("lit_dbz", div_by_zero, ez);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_quot", quot, eq);
      chk("hold_rem", rem, er);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("in_ready_after_handshake", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_op(100, 7, 14, 2, 0, 0, 1'b0);
    run_op(8191, 1, 8191, 0, 0, 0, 1'b0);
    run_op(6, 127, 0, 6, 0, 0, 1'b0);
    run_op(5, 0, 8191, 5, 1, 0, 1'b0);
    run_op(1000, 3, 333, 1, 0, 10, 1'b0);
    run_op(777, 25, 31, 2, 0, 0, 1'b1);

    // Abort a divide part-way through with reset.
    din0 = 13'd300;
    din1 = 7'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    m_busy = 1'b0;
    m_age  = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (15) step();
    run_op(200, 9, 22, 2, 0, 0, 1'b0);

    begin
      int cyc;
      int start_done;
      cyc = 0;
      start_done = n_done;
      while ((n_done - start_done) < 2500 && cyc < 80000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        rand_operands();
        step();
        cyc++;
      end
      chk("regression_completed", ((n_done - start_done) >= 2500), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
